kbd_autotype_arb: RTL

- Keystroke sequencer and arbiter in front of the RX-78 keyboard matrix block.
- Buffers scancodes written by the HPS (paste / auto-type for loading BASIC listings) in a FIFO.
- Replays each buffered scancode as timed press/release events on a ps2_key-format bus.
- Merges those events with live PS/2 traffic; the merged bus drives the matrix block's ps2_key input unchanged.

---
 rtl/kbd_autotype_arb.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/kbd_autotype_arb.sv
// Auto-type sequencer: FIFO-buffered scancodes replayed as timed ps2_key press/release events,
// merged with live PS/2 traffic. Define AUTOTYPE_SHIFT_EN to wrap bit9 entries in a shift press.
module kbd_autotype_arb #(
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned HOLD_CYCLES  = 640000,
  parameter int unsigned GAP_CYCLES   = 640000,
  parameter int unsigned QUIET_CYCLES = 1600000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key_in,
  input  logic [9:0]  wr_data,
  input  logic        wr_en,
  input  logic        abort,
  output logic [10:0] ps2_key_out,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned Depth     = 2 ** FIFO_AW;
  localparam logic [7:0]  ShiftCode = 8'h12;

`ifdef AUTOTYPE_SHIFT_EN
  typedef enum logic [2:0] {
    StIdle, StPress, StHold, StRelease, StGap, StShiftDn, StShiftGap, StShiftUp
  } state_e;
`else
  typedef enum logic [2:0] {StIdle, StPress, StHold, StRelease, StGap} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, quiet_q, quiet_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]       mem_q [Depth];
  logic [8:0]       cur_q, cur_d;
  logic [10:0]      out_q, out_d;
  logic             tog_q, ovf_q, ovf_d;
  logic             live_evt, empty, quiet, pop, push, auto_emit;
  logic [9:0]       head, auto_key;
  logic             shift_q;

`ifdef AUTOTYPE_SHIFT_EN
  logic shift_d;
`else
  logic unused_shift_req;
  assign shift_q          = 1'b0;
  assign unused_shift_req = head[9];
`endif

  assign live_evt    = ps2_key_in[10] ^ tog_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head        = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign quiet       = (quiet_q == '0);
  assign busy        = (state_q != StIdle) || !empty;
  assign overflow    = ovf_q;
  assign ps2_key_out = out_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    pop       = 1'b0;
    auto_emit = 1'b0;
    auto_key  = '0;
`ifdef AUTOTYPE_SHIFT_EN
    shift_d   = shift_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty && quiet && !abort) begin
`ifdef AUTOTYPE_SHIFT_EN
          state_d = head[9] ? StShiftDn : StPress;
`else
          state_d = StPress;
`endif
        end
      end
      StPress: begin
        // Once a shift press is out, an abort must still release everything.
        if (abort) begin
          state_d = shift_q ? StRelease : StIdle;
        end else if (!live_evt) begin
          auto_emit = 1'b1;
          auto_key  = {1'b1, (shift_q ? cur_q : head[8:0])};
          if (!shift_q) begin
            pop   = 1'b1;
            cur_d = head[8:0];
          end
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = StHold;
        end
      end
      StHold: begin
        // Leave one cycle early so the release lands HOLD_CYCLES after the press.
        if (abort || cnt_q <= CNT_W'(1)) state_d = StRelease;
        else                             cnt_d   = cnt_q - 1'b1;
      end
      StRelease: begin
        if (!live_evt) begin
          auto_emit = 1'b1;
          auto_key  = {1'b0, cur_q};
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
`ifdef AUTOTYPE_SHIFT_EN
          state_d   = shift_q ? StShiftUp : StGap;
`else
          state_d   = StGap;
`endif
        end
      end
      StGap: begin
        if (abort || cnt_q == '0) state_d = StIdle;
        else                      cnt_d   = cnt_q - 1'b1;
      end
`ifdef AUTOTYPE_SHIFT_EN
      StShiftDn: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!live_evt) begin
          auto_emit = 1'b1;
          auto_key  = {1'b1, 1'b0, ShiftCode};
          pop       = 1'b1;
          cur_d     = head[8:0];
          shift_d   = 1'b1;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = StShiftGap;
        end
      end
      StShiftGap: begin
        if (abort)               state_d = StRelease;
        else if (cnt_q == '0)    state_d = StPress;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      StShiftUp: begin
        if (!live_evt) begin
          auto_emit = 1'b1;
          auto_key  = {1'b0, 1'b0, ShiftCode};
          shift_d   = 1'b0;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = StGap;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (live_evt)       out_d = {~out_q[10], ps2_key_in[9:0]};
    else if (auto_emit) out_d = {~out_q[10], auto_key};

    quiet_d = live_evt ? CNT_W'(QUIET_CYCLES) : (quiet ? quiet_q : quiet_q - 1'b1);

    // A pop in the same cycle frees the slot, so a write on a full FIFO is still accepted.
    push     = wr_en && !abort && (!fifo_full || pop);
    wr_ptr_d = wr_ptr_q + (FIFO_AW + 1)'(push);
    rd_ptr_d = abort ? wr_ptr_q : rd_ptr_q + (FIFO_AW + 1)'(pop);
    ovf_d    = abort ? 1'b0 : (ovf_q || (wr_en && fifo_full && !pop));
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      quiet_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cur_q    <= '0;
      out_q    <= '0;
      tog_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quiet_q  <= quiet_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cur_q    <= cur_d;
      out_q    <= out_d;
      tog_q    <= ps2_key_in[10];
      ovf_q    <= ovf_d;
    end
  end

`ifdef AUTOTYPE_SHIFT_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) shift_q <= 1'b0;
    else       shift_q <= shift_d;
  end
`endif

endmodule
